// File: rtl/mont_pkg.sv
// -----------------------------------------------------------------------------
// mont_pkg
// Shared constants and the sequencer state type for the radix-2 Montgomery
// multiplier and its add/subtract/shift stage.
//   N_BITS  : operand / modulus width
//   ADD_W   : datapath width into the adder (N_BITS + 2 guard bits)
//   RES_W   : adder result width (ADD_W + carry/borrow bit)
//   LATENCY : cycles from the cycle start is presented to the done cycle
// -----------------------------------------------------------------------------
package mont_pkg;

  localparam int N_BITS  = 512;
  localparam int ADD_W   = N_BITS + 2;
  localparam int RES_W   = ADD_W + 1;
  localparam int LATENCY = 2 * N_BITS + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD_B = 3'd1,
    ADD_M = 3'd2,
    SUB   = 3'd3,
    SEL   = 3'd4
  } state_t;

endpackage

// File: rtl/montgomery_mult_seq_adder.sv
// -----------------------------------------------------------------------------
// adder
// Registered add / subtract / shift-right-by-one stage with one-cycle latency.
// A request presented with start=1 on one rising edge appears on result (and
// done=1) after that edge; result holds until the next request.
// Ports:
//   clk       : clock, rising edge
//   resetn    : synchronous active-low reset
//   start     : request strobe
//   subtract  : 1 -> in_a - in_b, 0 -> in_a + in_b
//   shift     : 1 -> result is the (unsigned) sum shifted right by one
//   in_a/in_b : W-bit unsigned operands
//   result    : W+1 bits; bit W is carry (add) or borrow (subtract)
//   done      : high the cycle after an accepted request
// -----------------------------------------------------------------------------
module adder
  import mont_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic         shift,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W:0]   result,
  output logic         done
);

  logic [W:0] w_sum;
  logic [W:0] w_out;

  always_comb begin
    if (subtract) begin
      w_sum = {1'b0, in_a} - {1'b0, in_b};
    end else begin
      w_sum = {1'b0, in_a} + {1'b0, in_b};
    end
    // The shift keeps the carry, so a full W+1-bit sum halves without loss.
    w_out = shift ? {1'b0, w_sum[W:1]} : w_sum;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result <= w_out;
      end
    end
  end

endmodule

// File: rtl/montgomery_mult_seq.sv
// -----------------------------------------------------------------------------
// montgomery_mult_seq
// Radix-2 bit-serial Montgomery multiplier: result = in_a * in_b * 2^-N mod in_m.
// Drives the registered adder stage every cycle and consumes its result one
// cycle after each issue; the adder's done is never waited on.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset (aborts any operation)
//   start  : request, sampled only in IDLE and not in the done cycle
//   in_a   : multiplier   (in_a < in_m)
//   in_b   : multiplicand (in_b < in_m)
//   in_m   : odd modulus
//   result : Montgomery product, held until the next accepted start
//   busy   : high from the accept edge until the done edge
//   done   : one-cycle pulse, result valid
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operands latched on accept
// ADD_B | issue C + (a[i] ? B : 0)
// ADD_M | issue (R + (R[0] ? M : 0)) >> 1, R = ADD_B result; i++ or finish
// SUB   | capture C (< 2M), issue C - M
// SEL   | pick C or C - M by borrow, register result and pulse done
// -----------------------------------------------------------------------------
module montgomery_mult_seq
  import mont_pkg::*;
#(
  parameter int N = N_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int AW = N + 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_m;
  logic [AW-1:0] r_c;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_result;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_consume;
  logic [AW-1:0] w_c_cur;
  logic          w_add_start;
  logic          w_add_sub;
  logic          w_add_shift;
  logic [AW-1:0] w_add_a;
  logic [AW-1:0] w_add_b;
  logic [AW:0]   w_add_res;
  logic          w_add_done;

  adder #(
    .W (AW)
  ) u_adder (
    .clk      (clk),
    .resetn   (~reset),
    .start    (w_add_start),
    .subtract (w_add_sub),
    .shift    (w_add_shift),
    .in_a     (w_add_a),
    .in_b     (w_add_b),
    .result   (w_add_res),
    .done     (w_add_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_add_start = 1'b0;
    w_add_sub   = 1'b0;
    w_add_shift = 1'b0;
    w_add_a     = '0;
    w_add_b     = '0;
    // Blocking start during the done cycle spaces back-to-back results 2N+4 apart.
    w_accept    = (r_state == IDLE) && start && !r_done;
    // On the first iteration the accumulator is the cleared register; after
    // that it is the halved sum the previous ADD_M just produced.
    w_c_cur     = (r_cnt == '0) ? r_c : w_add_res[AW-1:0];
    w_consume   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ADD_B;
        end
      end
      ADD_B: begin
        w_add_start = 1'b1;
        w_add_a     = w_c_cur;
        w_add_b     = r_a[r_cnt] ? {2'b00, r_b} : '0;
        w_consume   = (r_cnt != '0);
        w_state_nxt = ADD_M;
      end
      ADD_M: begin
        w_add_start = 1'b1;
        w_add_shift = 1'b1;
        w_add_a     = w_add_res[AW-1:0];
        w_add_b     = w_add_res[0] ? {2'b00, r_m} : '0;
        w_consume   = 1'b1;
        w_state_nxt = (r_cnt == LAST_BIT) ? SUB : ADD_B;
      end
      SUB: begin
        w_add_start = 1'b1;
        w_add_sub   = 1'b1;
        w_add_a     = w_add_res[AW-1:0];
        w_add_b     = {2'b00, r_m};
        w_consume   = 1'b1;
        w_state_nxt = SEL;
      end
      SEL: begin
        w_consume   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_c      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_m    <= in_m;
            r_c    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        ADD_B: begin
          r_c <= w_c_cur;
        end
        ADD_M: begin
          if (r_cnt != LAST_BIT) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        SUB: begin
          r_c <= w_add_res[AW-1:0];
        end
        SEL: begin
          // Borrow out of C - M means C < M, so C itself is already reduced.
          r_result <= w_add_res[AW] ? r_c[N-1:0] : w_add_res[N-1:0];
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // The adder is never polled: whenever a state reads its result, the
  // previous cycle's issue must already have landed.
  a_adder_ready : assert property (@(posedge clk) disable iff (reset)
    w_consume |-> w_add_done);

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_montgomery_mult_seq.sv
module tb_montgomery_mult_seq;
  import mont_pkg::*;

  localparam int N      = N_BITS;
  localparam int MAXCYC = LATENCY + 20;
  localparam int NVEC   = 8;
  localparam int NRAND  = 30;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;
  int cons_bad = 0;

  typedef struct {
    string        name;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[NVEC];

  montgomery_mult_seq #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Every cycle that reads the adder result must see adder done high.
  always @(negedge clk) begin
    if (!reset && dut.r_state != IDLE &&
        !(dut.r_state == ADD_B && dut.r_cnt == '0)) begin
      if (!dut.w_add_done) cons_bad++;
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents start for one cycle, counts edges until done (bounded).
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                        output int lat, output logic [N-1:0] res, output bit busy_ok);
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    busy_ok = 1'b1;
    next_cycle();
    start = 1'b0;
    lat = 1;
    while (!done && lat < MAXCYC) begin
      if (!busy) busy_ok = 1'b0;
      next_cycle();
      lat++;
    end
    if (busy) busy_ok = 1'b0;
    res = result;
  endtask

  function automatic logic [N-1:0] rnd_word();
    logic [N-1:0] v;
    for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [N-1:0] one, m0, p511, p510, res, a, b, m;
    logic [2*N-1:0] lhs, rhs, mm;
    int  lat, ndone;
    bit  bok;

    one  = 1;
    p511 = one << 511;
    p510 = one << 510;
    m0   = p511 | one;

    // m0 = 2^511+1: 2^511 = -1, 2^-1 = 2^510+1, so 2^-512 = 2^510.
    vecs[0] = '{"pow2",     p511,      N'(2),     one};
    vecs[1] = '{"finalsub", p511,      m0 - one,  p510};
    vecs[2] = '{"zero_a",   '0,        N'(12345), '0};
    vecs[3] = '{"zero_b",   N'(12345), '0,        '0};
    vecs[4] = '{"ones",     one,       one,       p510};
    vecs[5] = '{"neg_sq",   m0 - one,  m0 - one,  p510};
    vecs[6] = '{"swap",     N'(2),     p511,      one};
    vecs[7] = '{"three",    N'(3),     p511,      p510 + N'(2)};

    reset = 1'b1; start = 1'b0; in_a = '0; in_b = '0; in_m = '0;
    repeat (3) next_cycle();
    check("reset_result", result, '0);
    check("reset_busy_done", N'({busy, done}), '0);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, m0, lat, res, bok);
      check({vecs[i].name, "_latency"}, N'(lat), N'(LATENCY));
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_busy"}, N'(bok), N'(1));
      next_cycle();
    end

    // start pulsed again at cycle 100 with different operands must be ignored.
    in_a = p511; in_b = N'(2); in_m = m0; start = 1'b1;
    lat = 0;
    do begin
      next_cycle();
      lat++;
      start = (lat == 100);
      if (lat == 100) begin
        in_a = one; in_b = one;
      end
    end while (!done && lat < MAXCYC);
    check("busy_start_latency", N'(lat), N'(LATENCY));
    check("busy_start_result", result, one);
    ndone = 0;
    repeat (LATENCY + 20) begin
      next_cycle();
      if (done) ndone++;
    end
    check("busy_start_no_second_done", N'(ndone), '0);
    check("busy_start_result_held", result, one);

    // Reset at cycle 500 aborts; outputs clear and no done appears.
    in_a = p511; in_b = m0 - one; in_m = m0; start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (499) next_cycle();
    reset = 1'b1;
    next_cycle();
    check("abort_reset_result", result, '0);
    check("abort_reset_busy_done", N'({busy, done}), '0);
    repeat (2) next_cycle();
    reset = 1'b0;
    ndone = 0;
    repeat (600) begin
      next_cycle();
      if (done || busy) ndone++;
    end
    check("abort_no_done", N'(ndone), '0);
    run_op(p511, m0 - one, m0, lat, res, bok);
    check("after_abort_latency", N'(lat), N'(LATENCY));
    check("after_abort_result", res, p510);
    next_cycle();

    // Random odd moduli with MSB set, back-to-back; checked by definition:
    // res * 2^N == a * b (mod m) and res < m.
    for (int i = 0; i < NRAND; i++) begin
      m = rnd_word() | p511 | one;
      a = rnd_word() % m;
      b = rnd_word() % m;
      run_op(a, b, m, lat, res, bok);
      mm  = {{N{1'b0}}, m};
      lhs = {res, {N{1'b0}}} % mm;
      rhs = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % mm;
      check($sformatf("rand%0d_latency", i), N'(lat), N'(LATENCY));
      check($sformatf("rand%0d_congruence", i), lhs[N-1:0], rhs[N-1:0]);
      check($sformatf("rand%0d_reduced", i), N'(res < m), N'(1));
      check($sformatf("rand%0d_busy", i), N'(bok), N'(1));
      next_cycle();
    end

    check("adder_done_at_consume", N'(cons_bad), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
